pkt_rx_crc: RTL

Input-port packet receiver that sits directly upstream of the per-port synchronous FIFO. It parses each incoming byte-serial packet (header, payload, CRC-8), writes header and payload into the FIFO speculatively, and checks the CRC. It then either commits the packet with a write-pointer update or discards it with a flush. It also reports the packet destination and keeps good/bad packet counters.

---
 rtl/pkt_rx_crc.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pkt_rx_crc.sv
// Packet receiver: parses header/payload/CRC-8 bytes, pushes header and payload
// into the downstream FIFO speculatively, then commits or flushes on the CRC verdict.
module pkt_rx_crc #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  fifo_full,
    output logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_push,
    output logic                  fifo_wr_ptr_upd,
    output logic                  fifo_flush,
    output logic [ADDR_WIDTH-1:0] pkt_dest,
    output logic                  pkt_ok,
    output logic                  pkt_err,
    output logic [CNT_WIDTH-1:0]  ok_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    localparam int LEN_WIDTH = DATA_WIDTH - ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] POLY = DATA_WIDTH'(8'h07);

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CRC
    } state_t;

    state_t                 state, state_next;
    logic [DATA_WIDTH-1:0]  crc_r;
    logic [LEN_WIDTH-1:0]   rem_cnt;
    logic [ADDR_WIDTH-1:0]  dest_r;
    logic                   ovf_r;

    logic                   take_byte;
    logic                   crc_check;
    logic                   ovf_now;
    logic                   crc_good;

    function automatic logic [DATA_WIDTH-1:0] crc_step(input logic [DATA_WIDTH-1:0] crc,
                                                       input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] c;
        c = crc ^ b;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            c = c[DATA_WIDTH-1] ? ({c[DATA_WIDTH-2:0], 1'b0} ^ POLY) : {c[DATA_WIDTH-2:0], 1'b0};
        end
        return c;
    endfunction

    // A push still in flight when the CRC byte arrives belongs to this packet,
    // so the verdict folds in the current push/full pair as well as the sticky flag.
    always_comb begin
        state_next = state;
        take_byte  = 1'b0;
        crc_check  = 1'b0;
        ovf_now    = ovf_r | (fifo_push & fifo_full);
        crc_good   = (in_data == crc_r) && !ovf_now;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    take_byte  = 1'b1;
                    state_next = (in_data[DATA_WIDTH-1:ADDR_WIDTH] == '0) ? CRC : PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (in_valid) begin
                    take_byte = 1'b1;
                    if (rem_cnt == LEN_WIDTH'(1)) state_next = CRC;
                end
            end
            CRC: begin
                if (in_valid) begin
                    crc_check  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            crc_r           <= '0;
            rem_cnt         <= '0;
            dest_r          <= '0;
            ovf_r           <= 1'b0;
            fifo_data       <= '0;
            fifo_push       <= 1'b0;
            fifo_wr_ptr_upd <= 1'b0;
            fifo_flush      <= 1'b0;
            pkt_dest        <= '0;
            pkt_ok          <= 1'b0;
            pkt_err         <= 1'b0;
            ok_cnt          <= '0;
            err_cnt         <= '0;
        end else begin
            state           <= state_next;
            fifo_push       <= take_byte;
            fifo_wr_ptr_upd <= crc_check & crc_good;
            pkt_ok          <= crc_check & crc_good;
            fifo_flush      <= crc_check & !crc_good;
            pkt_err         <= crc_check & !crc_good;
            ovf_r           <= crc_check ? 1'b0 : ovf_now;

            if (take_byte) begin
                fifo_data <= in_data;
                crc_r     <= crc_step(crc_r, in_data);
            end else if (crc_check) begin
                crc_r <= '0;
            end

            if (take_byte && state == IDLE) begin
                rem_cnt <= in_data[DATA_WIDTH-1:ADDR_WIDTH];
                dest_r  <= in_data[ADDR_WIDTH-1:0];
            end else if (take_byte) begin
                rem_cnt <= rem_cnt - LEN_WIDTH'(1);
            end

            if (crc_check && crc_good) begin
                pkt_dest <= dest_r;
                if (ok_cnt != '1) ok_cnt <= ok_cnt + CNT_WIDTH'(1);
            end
            if (crc_check && !crc_good) begin
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule
